// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and sizing for the byte-wide RAM arbiter.
// len_in_byte is 3 bits wide; anything above MAX_LEN is treated as MAX_LEN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } arb_state_t;

  localparam int LEN_W   = 3;
  localparam int MAX_LEN = 4;
  localparam int BIDX_W  = $clog2(MAX_LEN + 1);

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] l
  );
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester side and RAM side of the arbiter in one bundle.
// slave = arbiter view, master = cpu/RAM environment view.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int NPORT = 2
);
  logic [NPORT-1:0]       re;
  logic [NPORT-1:0]       we;
  logic [32*NPORT-1:0]    addr;
  logic [32*NPORT-1:0]    w_data;
  logic [LEN_W*NPORT-1:0] len_in_byte;
  logic [32*NPORT-1:0]    r_data;
  logic [NPORT-1:0]       state_busy;
  logic [NPORT-1:0]       state_done;
  logic [31:0]            mem_a;
  logic [7:0]             mem_dout;
  logic [7:0]             mem_din;
  logic                   mem_wr;

  modport slave (
    input  re, we, addr, w_data, len_in_byte, mem_din,
    output r_data, state_busy, state_done,
    output mem_a, mem_dout, mem_wr
  );

  modport master (
    output re, we, addr, w_data, len_in_byte, mem_din,
    input  r_data, state_busy, state_done,
    input  mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational grant picker, one-hot and index out.
// MEM_ARB_RR_EN selects round-robin; otherwise highest index wins.
module arb_pick #(
  parameter int NPORT = 2,
  parameter int IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [NPORT-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);
`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] w_j;

  // scan from last+NPORT down to last+1 so the port after last wins
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = '0;
    for (int off = NPORT; off >= 1; off--) begin
      w_j = IW'((int'(i_last) + off) % NPORT);
      if (i_req[w_j]) o_idx = w_j;
    end
    if (|i_req) o_gnt[o_idx] = 1'b1;
  end
`else
  logic w_unused_last;

  assign w_unused_last = ^i_last;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (i_req[IW'(i)]) o_idx = IW'(i);
    end
    if (|i_req) o_gnt[o_idx] = 1'b1;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM bus among NPORT requesters.
// Grant is fixed priority unless MEM_ARB_RR_EN is defined (round-robin).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORT = 2
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  mem_arb_if.slave bus
);
  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  arb_state_t       r_state;
  arb_state_t       w_nxt;
  logic [IW-1:0]    r_port;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_gidx;
  logic [NPORT-1:0] w_req;
  logic [NPORT-1:0] w_gnt;
  logic             w_any;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rbuf;
  logic [31:0]      w_rfin;
  logic [31:0]      w_cur;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_glen;
  logic [BIDX_W-1:0] r_k;
  logic [1:0]       w_bsel;
  logic [31:0]      r_rdata [NPORT];

  assign w_req  = bus.re | bus.we;
  assign w_any  = |w_gnt;
  assign w_glen = clamp_len(bus.len_in_byte[LEN_W*w_gidx +: LEN_W]);
  assign w_cur  = r_addr + 32'(r_k);
  assign w_bsel = 2'(r_k - BIDX_W'(1));

  arb_pick #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx)
  );

  // mem_din lags mem_a by one cycle, so it lands in byte k-1
  always_comb begin
    w_rfin = r_rbuf;
    if (r_k != '0) w_rfin[8*w_bsel +: 8] = bus.mem_din;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_glen == '0)          w_nxt = S_DONE;
          else if (bus.we[w_gidx])   w_nxt = S_WRITE;
          else                       w_nxt = S_READ;
        end
      end
      S_READ:  if (r_k == r_len) w_nxt = S_DONE;
      S_WRITE: if (r_k == r_len - LEN_W'(1)) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_a      = '0;
    bus.mem_dout   = '0;
    bus.mem_wr     = 1'b0;
    bus.state_busy = '0;
    bus.state_done = '0;
    unique case (r_state)
      S_READ: begin
        if (r_k < r_len) bus.mem_a = w_cur;
        bus.state_busy[r_port] = 1'b1;
      end
      S_WRITE: begin
        bus.mem_a    = w_cur;
        bus.mem_dout = r_wdata[8*r_k +: 8];
        bus.mem_wr   = rdy_in;
        bus.state_busy[r_port] = 1'b1;
      end
      S_DONE:  bus.state_done[r_port] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bus.r_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      bus.r_data[32*i +: 32] = r_rdata[IW'(i)];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_port  <= '0;
      r_last  <= IW'(NPORT - 1);
      r_addr  <= '0;
      r_wdata <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_rbuf  <= '0;
      r_rdata <= '{default: '0};
    end else if (rdy_in) begin
      r_state <= w_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_port  <= w_gidx;
            r_last  <= w_gidx;
            r_addr  <= bus.addr[32*w_gidx +: 32];
            r_wdata <= bus.w_data[32*w_gidx +: 32];
            r_len   <= w_glen;
            r_k     <= '0;
            r_rbuf  <= '0;
            if (w_glen == '0 && !bus.we[w_gidx]) r_rdata[w_gidx] <= '0;
          end
        end
        S_READ: begin
          r_rbuf <= w_rfin;
          if (r_k < r_len) r_k <= r_k + BIDX_W'(1);
          else             r_rdata[r_port] <= w_rfin;
        end
        S_WRITE: r_k <= r_k + BIDX_W'(1);
        default: ;
      endcase
    end
  end
endmodule
